// File: rtl/seq_mul_radix4.sv
// Iterative radix-4 multiplier: sign-magnitude operands, two multiplier bits
// retired per cycle into a 2W-bit accumulator, sign applied in a final FIX cycle.
module seq_mul_radix4 #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi
);

  localparam int STEPS = WIDTH / 2;
  localparam int KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nx;
  logic                 neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH+1:0]     a3;
  logic [WIDTH-1:0]     b_sh;
  logic [2*WIDTH-1:0]   acc;
  logic [KW-1:0]        k;
  logic [WIDTH-1:0]     a_in_mag, b_in_mag;
  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH-1:0]   addend;

  // Most negative value maps onto 2^(W-1), which still fits as unsigned W bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign a_in_mag = magnitude(iA, iSigned);
  assign b_in_mag = magnitude(iB, iSigned);

  always_comb begin
    pp = '0;
    case (b_sh[1:0])
      2'b00:   pp = '0;
      2'b01:   pp = {2'b00, a_mag};
      2'b10:   pp = {1'b0, a_mag, 1'b0};
      default: pp = a3;
    endcase
  end

  assign addend = {{(WIDTH-2){1'b0}}, pp} << {k, 1'b0};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (iStart) state_nx = RUN;
      RUN:     if (k == KW'(STEPS - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oResultLo <= '0;
      oResultHi <= '0;
      neg       <= 1'b0;
      a_mag     <= '0;
      a3        <= '0;
      b_sh      <= '0;
      acc       <= '0;
      k         <= '0;
    end else begin
      state <= state_nx;
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            neg   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
            a_mag <= a_in_mag;
            b_sh  <= b_in_mag;
            a3    <= {2'b00, a_in_mag} + {1'b0, a_in_mag, 1'b0};
            acc   <= '0;
            k     <= '0;
            oBusy <= 1'b1;
          end
        end
        RUN: begin
          // b_sh is consumed two bits per step so its low pair is always digit k.
          acc  <= acc + addend;
          b_sh <= b_sh >> 2;
          k    <= k + {{(KW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          {oResultHi, oResultLo} <= neg ? negate(acc) : acc;
          oDone <= 1'b1;
          oBusy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
